// File: rtl/twiddle_apply_r4x16.sv
// twiddle_apply_r4x16: frames 16-sample groups, addresses the radix-4 twiddle ROM and applies a rounded, saturated complex multiply.
// Define TWIDDLE_CONJ_EN to multiply by the conjugate twiddle (IFFT direction).
module twiddle_apply_r4x16 #(
    parameter int DW     = 16,
    parameter int TW_W   = 18,
    parameter int ADDR_W = 4,
    parameter int SHIFT  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_sop,
    input  logic signed [DW-1:0]     in_re,
    input  logic signed [DW-1:0]     in_im,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [TW_W-1:0]          rom_data,
    output logic                     out_valid,
    output logic                     out_sop,
    output logic signed [DW-1:0]     out_re,
    output logic signed [DW-1:0]     out_im,
    output logic                     frame_err
);
    localparam int CW = TW_W / 2;
    localparam int PW = DW + CW;
    localparam int SW = DW + CW + 1;
    localparam logic signed [SW-1:0] MAXV = SW'((2 ** (DW - 1)) - 1);
    localparam logic signed [SW-1:0] MINV = -MAXV - SW'(1);
    localparam logic signed [SW-1:0] RND  = SW'(1) <<< (SHIFT - 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t                  state;
    logic [ADDR_W-1:0]       cnt;
    logic                    accept, restart, miss;
    logic                    s1_v, s1_sop, s2_v, s2_sop;
    logic signed [DW-1:0]    s1_re, s1_im;
    logic signed [CW-1:0]    tw_re, tw_im;
    logic signed [PW-1:0]    p_ac, p_bd, p_ad, p_bc;
    logic signed [SW-1:0]    sum_re, sum_im;
    function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] x);
        return (x > MAXV) ? MAXV[DW-1:0] : (x < MINV) ? MINV[DW-1:0] : x[DW-1:0];
    endfunction
    always_comb begin
        accept   = in_valid && (in_sop || (state == RUN && cnt != '0));
        restart  = in_valid && in_sop && state == RUN && cnt != '0;
        miss     = in_valid && !in_sop && state == RUN && cnt == '0;
        rom_addr = (in_valid && in_sop) ? '0 : cnt;
        tw_re    = rom_data[TW_W-1:CW];
`ifdef TWIDDLE_CONJ_EN
        // -(-256) does not fit in 9 bits, so it clamps to +255
        tw_im    = (rom_data[CW-1:0] == {1'b1, {(CW-1){1'b0}}}) ? {1'b0, {(CW-1){1'b1}}} : -$signed(rom_data[CW-1:0]);
`else
        tw_im    = rom_data[CW-1:0];
`endif
        sum_re   = ((SW'(p_ac) - SW'(p_bd)) + RND) >>> SHIFT;
        sum_im   = ((SW'(p_ad) + SW'(p_bc)) + RND) >>> SHIFT;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= restart || miss;
            if (accept) begin
                state <= RUN;
                cnt   <= in_sop ? ADDR_W'(1) : cnt + 1'b1;
            end else if (miss) begin
                state <= IDLE;
            end
        end
    end
    // ROM data for the S1 sample arrives in the same cycle, so products form on the S1->S2 edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s1_sop    <= 1'b0;
            s1_re     <= '0;
            s1_im     <= '0;
            s2_v      <= 1'b0;
            s2_sop    <= 1'b0;
            p_ac      <= '0;
            p_bd      <= '0;
            p_ad      <= '0;
            p_bc      <= '0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            s1_v      <= accept;
            s1_sop    <= accept && in_sop;
            s1_re     <= in_re;
            s1_im     <= in_im;
            s2_v      <= s1_v;
            s2_sop    <= s1_sop;
            p_ac      <= PW'(s1_re) * PW'(tw_re);
            p_bd      <= PW'(s1_im) * PW'(tw_im);
            p_ad      <= PW'(s1_re) * PW'(tw_im);
            p_bc      <= PW'(s1_im) * PW'(tw_re);
            out_valid <= s2_v;
            out_sop   <= s2_v && s2_sop;
            out_re    <= sat(sum_re);
            out_im    <= sat(sum_im);
        end
    end
endmodule

// File: tb/tb_twiddle_apply_r4x16.sv
// tb_twiddle_apply_r4x16: randomized and directed stimulus against a frame-level reference model with a cos/sin twiddle ROM.
module tb_twiddle_apply_r4x16;
    localparam real PI = 3.14159265358979323846;
    localparam int N = 2048;
    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, in_sop;
    logic signed [15:0] in_re, in_im;
    logic [3:0]         rom_addr;
    logic [17:0]        rom_data;
    logic               out_valid, out_sop, frame_err;
    logic signed [15:0] out_re, out_im;
    int     tre[16], tim[16];
    bit     ev[N], es[N], ee[N];
    longint er[N], ei[N];
    int     cyc = 0, checks = 0, errors = 0;
    bit     in_frame = 0;
    int     idx = 0;
    twiddle_apply_r4x16 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop),
        .in_re(in_re), .in_im(in_im), .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_sop(out_sop), .out_re(out_re), .out_im(out_im),
        .frame_err(frame_err)
    );
    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= {9'(tre[rom_addr]), 9'(tim[rom_addr])};
    task automatic check(string tag, longint got, longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask
    task automatic cmul(longint a, longint b, int ix, output longint re, output longint im);
        longint c, d;
        c = tre[ix];
        d = tim[ix];
`ifdef TWIDDLE_CONJ_EN
        d = (d == -256) ? 255 : -d;
`endif
        re = (a * c - b * d + 128) >>> 8;
        im = (a * d + b * c + 128) >>> 8;
        re = re > 32767 ? 32767 : re < -32768 ? -32768 : re;
        im = im > 32767 ? 32767 : im < -32768 ? -32768 : im;
    endtask
    task automatic check_out();
        check("out_valid", out_valid, ev[cyc]);
        check("out_sop", out_sop, ev[cyc] && es[cyc]);
        check("frame_err", frame_err, ee[cyc]);
        if (ev[cyc]) begin
            check("out_re", out_re, er[cyc]);
            check("out_im", out_im, ei[cyc]);
        end
    endtask
    task automatic step(bit v, bit s, int a, int b);
        bit acc = 0, err = 0;
        int ix = 0;
        in_valid = v;
        in_sop   = s;
        in_re    = 16'(a);
        in_im    = 16'(b);
        #1;
        check("rom_addr", rom_addr, (v && s) ? 0 : idx);
        if (v) begin
            if (s) begin
                err = in_frame && idx != 0;
                acc = 1;
                in_frame = 1;
                idx = 1;
            end else if (in_frame && idx == 0) begin
                err = 1;
                in_frame = 0;
            end else if (in_frame) begin
                acc = 1;
                ix = idx;
                idx = (idx + 1) % 16;
            end
        end
        if (acc) begin
            ev[cyc+3] = 1;
            es[cyc+3] = (ix == 0);
            cmul(longint'(in_re), longint'(in_im), ix, er[cyc+3], ei[cyc+3]);
        end
        ee[cyc+1] = err;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_out();
    endtask
    task automatic do_reset();
        in_valid = 0;
        in_sop   = 0;
        rst      = 1;
        for (int i = cyc + 1; i < N; i++) begin
            ev[i] = 0;
            ee[i] = 0;
        end
        in_frame = 0;
        idx = 0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_sop", out_sop, 0);
        check("rst_re", out_re, 0);
        check("rst_im", out_im, 0);
        check("rst_err", frame_err, 0);
        check("rst_addr", rom_addr, 0);
        rst = 0;
    endtask
    function automatic int rnd16();
        return int'($signed(16'($urandom)));
    endfunction
    initial begin
        for (int i = 0; i < 16; i++) begin
            int k = (i >> 2) * (i & 3);
            tre[i] = $rtoi(255.0 * $cos(2.0 * PI * k / 16.0));
            tim[i] = $rtoi(-255.0 * $sin(2.0 * PI * k / 16.0));
        end
        in_re = 0;
        in_im = 0;
        @(negedge clk);
        do_reset();
        step(1, 1, 1000, 0);
        repeat (4) step(0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(1, i == 0, 1000, 0);
        for (int i = 0; i < 16; i++)
            step(1, i == 0, i == 5 ? -32768 : rnd16(), i == 5 ? -32768 : rnd16());
        for (int i = 0; i < 7; i++) step(1, i == 0, rnd16(), rnd16());
        step(1, 1, 1000, 0);
        for (int i = 1; i < 16; i++) step(1, 0, rnd16(), rnd16());
        repeat (4) step(1, 0, rnd16(), rnd16());
        repeat (4) step(0, 0, 0, 0);
        step(1, 1, rnd16(), rnd16());
        for (int i = 1; i < 9; i++) begin
            step(0, 1'($urandom), rnd16(), rnd16());
            step(1, 0, rnd16(), rnd16());
        end
        step(1, 0, rnd16(), rnd16());
        do_reset();
        repeat (4) step(0, 0, 0, 0);
        repeat (3) step(1, 0, rnd16(), rnd16());
        for (int i = 0; i < 700; i++)
            step($urandom_range(3) != 0, $urandom_range(13) == 0, rnd16(), rnd16());
        repeat (4) step(0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
